cnn_layer_accel_octo_input_sched: RTL and testbench

//  Schedules the single upstream input stream onto C_NUM_OCTO cnn_layer_accel_octo instances.

---
 rtl/cnn_layer_accel_octo_input_sched_pkg.sv | 25 ++
 rtl/cnn_layer_accel_octo_input_sched_rr_arb.sv | 44 ++++
 rtl/cnn_layer_accel_octo_input_sched.sv | 171 +++++++++++++++++
 tb/tb_cnn_layer_accel_octo_input_sched.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_octo_input_sched_pkg.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_octo_input_sched_pkg
//   Shared definitions for the octo input scheduler: one-hot FSM state
//   encodings, tag polarity constants and the grant-index width helper.
// -----------------------------------------------------------------------------
package cnn_layer_accel_octo_input_sched_pkg;

   // One-hot scheduler states
   typedef enum logic [3:0] {
      ST_IDLE      = 4'b0001,
      ST_ARB       = 4'b0010,
      ST_SEQ_BCAST = 4'b0100,
      ST_PIX_XFER  = 4'b1000
   } sched_state_t;

   // Level driven on a tag line when the word belongs to that kind
   localparam logic SCHED_TAG_SEQ = 1'b1;
   localparam logic SCHED_TAG_PIX = 1'b1;

   // Width of an octo index; never below one bit so a single-octo build still has a port
   function automatic int sched_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cnn_layer_accel_octo_input_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_octo_input_sched_rr_arb
//   Combinational round-robin pick: returns the first asserted request at or
//   after the pointer, wrapping modulo C_NUM_REQ.
//   i_req      requests (already masked by enable and ready)
//   i_ptr      search start index
//   o_gnt_id   chosen index (0 when nothing requested)
//   o_gnt_vld  at least one request asserted
// -----------------------------------------------------------------------------
module cnn_layer_accel_octo_input_sched_rr_arb
   import cnn_layer_accel_octo_input_sched_pkg::*;
#(
   parameter  int C_NUM_REQ = 4,
   localparam int C_ID_W    = sched_id_w(C_NUM_REQ)
) (
   input  logic [C_NUM_REQ-1:0] i_req,
   input  logic [C_ID_W-1:0]    i_ptr,
   output logic [C_ID_W-1:0]    o_gnt_id,
   output logic                 o_gnt_vld
);

   logic [C_ID_W:0]   w_sum;
   logic [C_ID_W:0]   w_wrap;
   logic [C_ID_W-1:0] w_gnt_id;
   logic              w_found;

   // Walk the requests starting at the pointer; first hit wins
   always_comb begin
      w_sum    = {(C_ID_W+1){1'b0}};
      w_wrap   = {(C_ID_W+1){1'b0}};
      w_gnt_id = {C_ID_W{1'b0}};
      w_found  = 1'b0;
      for (int off = 0; off < C_NUM_REQ; off++) begin
         w_sum    = {1'b0, i_ptr} + (C_ID_W+1)'(off);
         w_wrap   = (w_sum >= (C_ID_W+1)'(C_NUM_REQ)) ? (w_sum - (C_ID_W+1)'(C_NUM_REQ)) : w_sum;
         w_gnt_id = (!w_found && i_req[w_wrap[C_ID_W-1:0]]) ? w_wrap[C_ID_W-1:0] : w_gnt_id;
         w_found  = w_found | i_req[w_wrap[C_ID_W-1:0]];
      end
   end

   assign o_gnt_id  = w_gnt_id;
   assign o_gnt_vld = w_found;

endmodule

// File: rtl/cnn_layer_accel_octo_input_sched.sv
// -----------------------------------------------------------------------------
// cnn_layer_accel_octo_input_sched
//   Steers the single upstream stream onto C_NUM_OCTO octo instances.
//   Sequencer bursts are broadcast to all enabled octos; each pixel burst goes
//   to one octo picked round-robin among enabled octos with pixel room.
//   Control : clk, rst (async, active-low), cfg_start, cfg_octo_en, cfg_stop
//   Upstream: up_data, up_valid, up_is_seq, up_last -> up_rdy
//   Octos   : octo_seq_rdy, octo_pixel_rdy -> octo_datain, octo_datain_valid,
//             octo_seq_tag, octo_pixel_tag (all registered, 1-cycle latency)
//   Status  : grant_id, busy, proto_err (sticky), rows_done (wrapping)
// -----------------------------------------------------------------------------
module cnn_layer_accel_octo_input_sched
   import cnn_layer_accel_octo_input_sched_pkg::*;
#(
   parameter  int C_NUM_OCTO    = 4,
   parameter  int C_PIXEL_WIDTH = 18,
   parameter  int C_ROW_CNT_W   = 16,
   localparam int C_ID_W        = sched_id_w(C_NUM_OCTO)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_start,
   input  logic [C_NUM_OCTO-1:0]    cfg_octo_en,
   input  logic                     cfg_stop,
   input  logic [C_PIXEL_WIDTH-1:0] up_data,
   input  logic                     up_valid,
   input  logic                     up_is_seq,
   input  logic                     up_last,
   output logic                     up_rdy,
   input  logic [C_NUM_OCTO-1:0]    octo_seq_rdy,
   input  logic [C_NUM_OCTO-1:0]    octo_pixel_rdy,
   output logic [C_PIXEL_WIDTH-1:0] octo_datain,
   output logic [C_NUM_OCTO-1:0]    octo_datain_valid,
   output logic [C_NUM_OCTO-1:0]    octo_seq_tag,
   output logic [C_NUM_OCTO-1:0]    octo_pixel_tag,
   output logic [C_ID_W-1:0]        grant_id,
   output logic                     busy,
   output logic                     proto_err,
   output logic [C_ROW_CNT_W-1:0]   rows_done
);

   sched_state_t             r_state;
   logic [C_NUM_OCTO-1:0]    r_mask;
   logic [C_NUM_OCTO-1:0]    r_valid;
   logic [C_NUM_OCTO-1:0]    r_seq_tag;
   logic [C_NUM_OCTO-1:0]    r_pix_tag;
   logic [C_PIXEL_WIDTH-1:0] r_datain;
   logic [C_ID_W-1:0]        r_grant_id;
   logic [C_ID_W-1:0]        r_rr_ptr;
   logic                     r_proto_err;
   logic [C_ROW_CNT_W-1:0]   r_rows_done;

   logic                     w_up_rdy;
   logic                     w_xfer;
   logic                     w_arb_vld;
   logic [C_ID_W-1:0]        w_arb_id;
   logic [C_ID_W-1:0]        w_rr_next;
   logic [C_NUM_OCTO-1:0]    w_grant_oh;
   logic [C_NUM_OCTO-1:0]    w_pix_req;

   assign w_pix_req  = r_mask & octo_pixel_rdy;
   assign w_grant_oh = C_NUM_OCTO'(1) << r_grant_id;
   assign w_rr_next  = (r_grant_id == C_ID_W'(C_NUM_OCTO - 1)) ? {C_ID_W{1'b0}}
                                                                 : r_grant_id + C_ID_W'(1);
   assign w_xfer     = up_valid & w_up_rdy;

   cnn_layer_accel_octo_input_sched_rr_arb #(
      .C_NUM_REQ (C_NUM_OCTO)
   ) u_rr_arb (
      .i_req     (w_pix_req),
      .i_ptr     (r_rr_ptr),
      .o_gnt_id  (w_arb_id),
      .o_gnt_vld (w_arb_vld)
   );

   // Upstream ready: broadcast waits for every enabled octo (disabled ones are
   // don't-care); a pixel burst only watches its granted octo. The octo-side
   // prefetch slack lets this path stay combinational without a skid buffer.
   always_comb begin
      w_up_rdy = 1'b0;
      case (r_state)
         ST_SEQ_BCAST: w_up_rdy = &(octo_seq_rdy | ~r_mask);
         ST_PIX_XFER:  w_up_rdy = octo_pixel_rdy[r_grant_id];
         default:      w_up_rdy = 1'b0;
      endcase
   end

   // Scheduler FSM with registered datapath, round-robin pointer and row counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_mask      <= {C_NUM_OCTO{1'b0}};
         r_valid     <= {C_NUM_OCTO{1'b0}};
         r_seq_tag   <= {C_NUM_OCTO{1'b0}};
         r_pix_tag   <= {C_NUM_OCTO{1'b0}};
         r_datain    <= {C_PIXEL_WIDTH{1'b0}};
         r_grant_id  <= {C_ID_W{1'b0}};
         r_rr_ptr    <= {C_ID_W{1'b0}};
         r_proto_err <= 1'b0;
         r_rows_done <= {C_ROW_CNT_W{1'b0}};
      end else begin
         // valid/tags are single-cycle strobes following each transfer
         r_valid   <= {C_NUM_OCTO{1'b0}};
         r_seq_tag <= {C_NUM_OCTO{1'b0}};
         r_pix_tag <= {C_NUM_OCTO{1'b0}};
         case (r_state)
            ST_IDLE: begin
               if (cfg_start && (cfg_octo_en != {C_NUM_OCTO{1'b0}})) begin
                  r_mask      <= cfg_octo_en;
                  r_rows_done <= {C_ROW_CNT_W{1'b0}};
                  r_proto_err <= 1'b0;
                  r_state     <= ST_ARB;
               end
            end
            ST_ARB: begin
               if (cfg_stop) begin
                  r_state <= ST_IDLE;
               end else if (up_valid && up_is_seq) begin
                  r_state <= ST_SEQ_BCAST;
               end else if (up_valid && w_arb_vld) begin
                  r_grant_id <= w_arb_id;
                  r_state    <= ST_PIX_XFER;
               end
            end
            ST_SEQ_BCAST: begin
               if (w_xfer) begin
                  r_datain  <= up_data;
                  r_valid   <= r_mask;
                  r_seq_tag <= r_mask & {C_NUM_OCTO{SCHED_TAG_SEQ}};
                  // kind flipped inside a burst: still routed by state, flagged
                  if (!up_is_seq) begin
                     r_proto_err <= 1'b1;
                  end
                  if (up_last) begin
                     r_state <= ST_ARB;
                  end
               end
            end
            ST_PIX_XFER: begin
               if (w_xfer) begin
                  r_datain  <= up_data;
                  r_valid   <= w_grant_oh;
                  r_pix_tag <= w_grant_oh & {C_NUM_OCTO{SCHED_TAG_PIX}};
                  if (up_is_seq) begin
                     r_proto_err <= 1'b1;
                  end
                  if (up_last) begin
                     r_rr_ptr    <= w_rr_next;
                     r_rows_done <= r_rows_done + C_ROW_CNT_W'(1);
                     r_state     <= ST_ARB;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign up_rdy            = w_up_rdy;
   assign octo_datain       = r_datain;
   assign octo_datain_valid = r_valid;
   assign octo_seq_tag      = r_seq_tag;
   assign octo_pixel_tag    = r_pix_tag;
   assign grant_id          = r_grant_id;
   assign busy              = (r_state != ST_IDLE);
   assign proto_err         = r_proto_err;
   assign rows_done         = r_rows_done;

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_sched.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_accel_octo_input_sched
//   Directed bench for the octo input scheduler (4 octos, 18-bit data).
//   Inputs change on the falling edge; registered outputs are read at the
//   following falling edge, up_rdy is read 1 ns after the inputs settle.
// -----------------------------------------------------------------------------
module tb_cnn_layer_accel_octo_input_sched;

   logic        clk;
   logic        rst;
   logic        cfg_start;
   logic [3:0]  cfg_octo_en;
   logic        cfg_stop;
   logic [17:0] up_data;
   logic        up_valid;
   logic        up_is_seq;
   logic        up_last;
   logic        up_rdy;
   logic [3:0]  octo_seq_rdy;
   logic [3:0]  octo_pixel_rdy;
   logic [17:0] octo_datain;
   logic [3:0]  octo_datain_valid;
   logic [3:0]  octo_seq_tag;
   logic [3:0]  octo_pixel_tag;
   logic [1:0]  grant_id;
   logic        busy;
   logic        proto_err;
   logic [15:0] rows_done;

   int n_tests = 0;
   int n_fail  = 0;

   cnn_layer_accel_octo_input_sched #(
      .C_NUM_OCTO    (4),
      .C_PIXEL_WIDTH (18),
      .C_ROW_CNT_W   (16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_start         (cfg_start),
      .cfg_octo_en       (cfg_octo_en),
      .cfg_stop          (cfg_stop),
      .up_data           (up_data),
      .up_valid          (up_valid),
      .up_is_seq         (up_is_seq),
      .up_last           (up_last),
      .up_rdy            (up_rdy),
      .octo_seq_rdy      (octo_seq_rdy),
      .octo_pixel_rdy    (octo_pixel_rdy),
      .octo_datain       (octo_datain),
      .octo_datain_valid (octo_datain_valid),
      .octo_seq_tag      (octo_seq_tag),
      .octo_pixel_tag    (octo_pixel_tag),
      .grant_id          (grant_id),
      .busy              (busy),
      .proto_err         (proto_err),
      .rows_done         (rows_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [3:0] m);
      @(negedge clk);
      cfg_start   = 1'b1;
      cfg_octo_en = m;
      @(negedge clk);
      cfg_start   = 1'b0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; cfg_start = 1'b0; cfg_octo_en = 4'h0; cfg_stop = 1'b0;
      up_data = 18'h0; up_valid = 1'b0; up_is_seq = 1'b0; up_last = 1'b0;
      octo_seq_rdy = 4'hF; octo_pixel_rdy = 4'hF;
      #12;
      n_tests++;
      if ({up_rdy, octo_datain, octo_datain_valid, octo_seq_tag, octo_pixel_tag,
           grant_id, busy, proto_err, rows_done} !== 50'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdy=%b d=%h v=%b st=%b pt=%b g=%0d busy=%b err=%b rows=%0d, all 0 required",
                  up_rdy, octo_datain, octo_datain_valid, octo_seq_tag, octo_pixel_tag,
                  grant_id, busy, proto_err, rows_done);
      end
      @(negedge clk);
      rst = 1'b1;
      do_start(4'h0);
      n_tests++;
      if ({busy, up_rdy} !== 2'b00) begin
         n_fail++;
         $display("FAIL start_mask0_ignored: got busy=%b rdy=%b, required 0 0", busy, up_rdy);
      end
   endtask

   task automatic test_seq_bcast();
      do_start(4'hF);
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: got %b required 1", busy);
      end
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b1; up_data = 18'h100; up_last = 1'b0;
      #1;
      n_tests++;
      if (up_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL arb_rdy_low: got %b required 0", up_rdy);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         up_data = 18'h100 + 18'(i);
         up_last = (i == 4);
         #1;
         n_tests++;
         if (up_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_rdy[%0d]: got %b required 1", i, up_rdy);
         end
         @(negedge clk);
         n_tests++;
         if ({octo_datain, octo_datain_valid, octo_seq_tag, octo_pixel_tag} !==
             {18'h100 + 18'(i), 4'hF, 4'hF, 4'h0}) begin
            n_fail++;
            $display("FAIL seq_beat[%0d]: got d=%h v=%b st=%b pt=%b, required d=%h v=1111 st=1111 pt=0000",
                     i, octo_datain, octo_datain_valid, octo_seq_tag, octo_pixel_tag, 18'h100 + 18'(i));
         end
      end
      up_valid = 1'b0; up_last = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({octo_datain_valid, octo_seq_tag, up_rdy} !== 9'h0) begin
         n_fail++;
         $display("FAIL seq_after_last: got v=%b st=%b rdy=%b, required 0", octo_datain_valid, octo_seq_tag, up_rdy);
      end
   endtask

   task automatic test_seq_stall();
      int  idx;
      logic exp_rdy;
      idx = 0;
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b1; up_data = 18'h300; up_last = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 7; c++) begin
         exp_rdy      = !(c >= 1 && c <= 3);
         octo_seq_rdy = exp_rdy ? 4'b1111 : 4'b1011;
         up_data      = 18'h300 + 18'(idx);
         up_last      = (idx == 3);
         #1;
         n_tests++;
         if (up_rdy !== exp_rdy) begin
            n_fail++;
            $display("FAIL stall_rdy[c%0d]: got %b required %b", c, up_rdy, exp_rdy);
         end
         @(negedge clk);
         n_tests++;
         if (exp_rdy) begin
            if ({octo_datain, octo_datain_valid} !== {18'h300 + 18'(idx), 4'hF}) begin
               n_fail++;
               $display("FAIL stall_beat[c%0d]: got d=%h v=%b, required d=%h v=1111",
                        c, octo_datain, octo_datain_valid, 18'h300 + 18'(idx));
            end
            idx++;
         end else begin
            if (octo_datain_valid !== 4'h0) begin
               n_fail++;
               $display("FAIL stall_novalid[c%0d]: got v=%b required 0000", c, octo_datain_valid);
            end
         end
      end
      up_valid = 1'b0; up_last = 1'b0; octo_seq_rdy = 4'hF;
      @(negedge clk);
      n_tests++;
      if ({octo_datain_valid, up_rdy} !== 5'h0) begin
         n_fail++;
         $display("FAIL stall_end: got v=%b rdy=%b (extra beat or not back in arb), required 0", octo_datain_valid, up_rdy);
      end
   endtask

   task automatic test_pixel_rr();
      logic [1:0] g[4];
      logic [3:0] oh;
      g[0] = 2'd0; g[1] = 2'd1; g[2] = 2'd3; g[3] = 2'd0;
      do_stop();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle: got busy=%b required 0", busy);
      end
      do_start(4'b1011);
      octo_pixel_rdy = 4'hF;
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b0; up_data = 18'h200; up_last = 1'b0;
      for (int b = 0; b < 4; b++) begin
         oh = 4'b0001 << g[b];
         @(negedge clk);
         n_tests++;
         if ({grant_id, octo_datain_valid} !== {g[b], 4'h0}) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got g=%0d v=%b, required g=%0d v=0000", b, grant_id, octo_datain_valid, g[b]);
         end
         #1;
         n_tests++;
         if (up_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_rdy[%0d]: got %b required 1", b, up_rdy);
         end
         @(negedge clk);
         n_tests++;
         if ({octo_datain, octo_datain_valid, octo_pixel_tag, octo_seq_tag} !==
             {18'h200 + 18'(2*b), oh, oh, 4'h0}) begin
            n_fail++;
            $display("FAIL rr_beat0[%0d]: got d=%h v=%b pt=%b st=%b, required d=%h v=%b pt=%b st=0000",
                     b, octo_datain, octo_datain_valid, octo_pixel_tag, octo_seq_tag, 18'h200 + 18'(2*b), oh, oh);
         end
         up_data = 18'h201 + 18'(2*b); up_last = 1'b1;
         @(negedge clk);
         n_tests++;
         if ({octo_datain, octo_datain_valid} !== {18'h201 + 18'(2*b), oh}) begin
            n_fail++;
            $display("FAIL rr_beat1[%0d]: got d=%h v=%b, required d=%h v=%b",
                     b, octo_datain, octo_datain_valid, 18'h201 + 18'(2*b), oh);
         end
         if (b < 3) begin
            up_data = 18'h200 + 18'(2*(b+1)); up_last = 1'b0;
         end else begin
            up_valid = 1'b0; up_last = 1'b0;
         end
      end
      @(negedge clk);
      n_tests++;
      if ({rows_done, octo_datain_valid} !== {16'd4, 4'h0}) begin
         n_fail++;
         $display("FAIL rr_rows: got rows=%0d v=%b, required rows=4 v=0000", rows_done, octo_datain_valid);
      end
   endtask

   task automatic test_pixel_stall();
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b0; up_data = 18'h0E0; up_last = 1'b0;
      @(negedge clk);
      n_tests++;
      if (grant_id !== 2'd1) begin
         n_fail++;
         $display("FAIL pst_grant: got %0d required 1", grant_id);
      end
      @(negedge clk);
      n_tests++;
      if ({octo_datain, octo_datain_valid} !== {18'h0E0, 4'b0010}) begin
         n_fail++;
         $display("FAIL pst_beat0: got d=%h v=%b, required d=0e0 v=0010", octo_datain, octo_datain_valid);
      end
      up_data = 18'h0E1; octo_pixel_rdy = 4'b1101;
      for (int s = 0; s < 2; s++) begin
         #1;
         n_tests++;
         if (up_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL pst_rdy_low[%0d]: got %b required 0", s, up_rdy);
         end
         @(negedge clk);
         n_tests++;
         if ({grant_id, octo_datain_valid, octo_pixel_tag} !== {2'd1, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL pst_hold[%0d]: got g=%0d v=%b pt=%b, required g=1 v=0000 pt=0000",
                     s, grant_id, octo_datain_valid, octo_pixel_tag);
         end
      end
      octo_pixel_rdy = 4'hF;
      @(negedge clk);
      n_tests++;
      if ({octo_datain, octo_datain_valid} !== {18'h0E1, 4'b0010}) begin
         n_fail++;
         $display("FAIL pst_beat1: got d=%h v=%b, required d=0e1 v=0010", octo_datain, octo_datain_valid);
      end
      up_data = 18'h0E2; up_last = 1'b1;
      @(negedge clk);
      up_valid = 1'b0; up_last = 1'b0;
      n_tests++;
      if ({octo_datain, octo_datain_valid} !== {18'h0E2, 4'b0010}) begin
         n_fail++;
         $display("FAIL pst_beat2: got d=%h v=%b, required d=0e2 v=0010", octo_datain, octo_datain_valid);
      end
      @(negedge clk);
      n_tests++;
      if (rows_done !== 16'd5) begin
         n_fail++;
         $display("FAIL pst_rows: got %0d required 5", rows_done);
      end
   endtask

   task automatic test_proto_err();
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b0; up_data = 18'h050; up_last = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({grant_id, proto_err} !== {2'd3, 1'b0}) begin
         n_fail++;
         $display("FAIL perr_grant: got g=%0d err=%b, required g=3 err=0", grant_id, proto_err);
      end
      for (int k = 0; k < 4; k++) begin
         up_data   = 18'h050 + 18'(k);
         up_is_seq = (k == 2);
         up_last   = (k == 3);
         @(negedge clk);
         n_tests++;
         if ({octo_datain, octo_datain_valid, octo_pixel_tag, octo_seq_tag, proto_err} !==
             {18'h050 + 18'(k), 4'b1000, 4'b1000, 4'h0, (k >= 2)}) begin
            n_fail++;
            $display("FAIL perr_beat[%0d]: got d=%h v=%b pt=%b st=%b err=%b, required d=%h v=1000 pt=1000 st=0000 err=%b",
                     k, octo_datain, octo_datain_valid, octo_pixel_tag, octo_seq_tag, proto_err,
                     18'h050 + 18'(k), (k >= 2));
         end
      end
      up_valid = 1'b0; up_is_seq = 1'b0; up_last = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({rows_done, proto_err} !== {16'd6, 1'b1}) begin
         n_fail++;
         $display("FAIL perr_sticky: got rows=%0d err=%b, required rows=6 err=1", rows_done, proto_err);
      end
      do_stop();
      do_start(4'hF);
      n_tests++;
      if ({rows_done, proto_err, busy} !== {16'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL perr_clear: got rows=%0d err=%b busy=%b, required 0 0 1", rows_done, proto_err, busy);
      end
   endtask

   task automatic test_async_reset();
      // single-beat burst: pointer wrapped to 0 so octo 0 gets it
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b0; up_data = 18'h0AA; up_last = 1'b1;
      @(negedge clk);
      n_tests++;
      if (grant_id !== 2'd0) begin
         n_fail++;
         $display("FAIL single_grant: got %0d required 0", grant_id);
      end
      @(negedge clk);
      n_tests++;
      if ({octo_datain, octo_datain_valid} !== {18'h0AA, 4'b0001}) begin
         n_fail++;
         $display("FAIL single_beat: got d=%h v=%b, required d=0aa v=0001", octo_datain, octo_datain_valid);
      end
      up_data = 18'h0B0; up_last = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({grant_id, rows_done} !== {2'd1, 16'd1}) begin
         n_fail++;
         $display("FAIL single_rows: got g=%0d rows=%0d, required g=1 rows=1", grant_id, rows_done);
      end
      @(negedge clk);
      n_tests++;
      if (octo_datain_valid !== 4'b0010) begin
         n_fail++;
         $display("FAIL rst_pre: got v=%b required 0010", octo_datain_valid);
      end
      #2;
      rst = 1'b0;
      #1;
      n_tests++;
      if ({up_rdy, octo_datain, octo_datain_valid, octo_seq_tag, octo_pixel_tag,
           grant_id, busy, proto_err, rows_done} !== 50'h0) begin
         n_fail++;
         $display("FAIL rst_async: got rdy=%b d=%h v=%b g=%0d busy=%b rows=%0d, all 0 required",
                  up_rdy, octo_datain, octo_datain_valid, grant_id, busy, rows_done);
      end
      up_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      do_start(4'hF);
      @(negedge clk);
      up_valid = 1'b1; up_is_seq = 1'b0; up_data = 18'h0C0; up_last = 1'b1;
      @(negedge clk);
      @(negedge clk);
      up_valid = 1'b0; up_last = 1'b0;
      n_tests++;
      if ({grant_id, octo_datain, octo_datain_valid} !== {2'd0, 18'h0C0, 4'b0001}) begin
         n_fail++;
         $display("FAIL rst_restart: got g=%0d d=%h v=%b, required g=0 d=0c0 v=0001",
                  grant_id, octo_datain, octo_datain_valid);
      end
      @(negedge clk);
      n_tests++;
      if (rows_done !== 16'd1) begin
         n_fail++;
         $display("FAIL rst_restart_rows: got %0d required 1", rows_done);
      end
   endtask

   initial begin
      test_reset();
      test_seq_bcast();
      test_seq_stall();
      test_pixel_rr();
      test_pixel_stall();
      test_proto_err();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
